// File: rtl/wash_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wash_cycle_ctrl
// Description : Cycle sequencer for the washing machine controller. It runs
//               the phases fill, wash and spin, then RINSE_CNT passes of
//               fill, rinse and spin, an optional dry phase, and then done.
//               It drives the phase timer (clear pulse and load size) and
//               takes the timer's per-phase done flags. Opening the door
//               pauses the cycle. Abort cancels it.
// Options     : DRY_PHASE_EN - when defined, the final spin goes to a heated
//               dry phase. When undefined, the final spin goes straight to
//               done, td is unused and heater is held at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module wash_cycle_ctrl #(
  parameter int RINSE_CNT = 2,
  parameter int BLANK     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       door_closed,
  input  logic [2:0] load,
  input  logic       tf,
  input  logic       tw,
  input  logic       tr,
  input  logic       ts,
  input  logic       td,
  output logic       tmr_clr,
  output logic [2:0] tmr_load,
  output logic [2:0] phase,
  output logic       fill_valve,
  output logic       motor_wash,
  output logic       motor_spin,
  output logic       drain_valve,
  output logic       heater,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DRY   = 3'd5,
    S_DONE  = 3'd6,
    S_PAUSE = 3'd7
  } state_t;

  localparam int                   c_BLANK_W    = $clog2(BLANK + 1);
  localparam logic [c_BLANK_W-1:0] c_BLANK_INIT = c_BLANK_W'(BLANK);
  localparam logic [2:0]           c_RINSE      = 3'(RINSE_CNT);

`ifdef DRY_PHASE_EN
  localparam state_t c_FINAL = S_DRY;
`else
  localparam state_t c_FINAL = S_DONE;
`endif

  state_t               r_state;
  state_t               r_resume;
  logic [2:0]           r_rinse;
  logic                 r_is_rinse;
  logic                 r_armed;
  logic [c_BLANK_W-1:0] r_blank;

  state_t w_nxt;
  state_t w_target;
  logic   w_active;
  logic   w_flag;
  logic   w_nxt_run;
  logic   w_entry;
  logic   w_abort;
  logic   w_begin;

  // Pick the done flag and successor that belong to the current timed phase
  always_comb begin
    w_active = 1'b0;
    w_flag   = 1'b0;
    w_target = r_state;
    case (r_state)
      S_FILL: begin
        w_active = 1'b1;
        w_flag   = tf;
        w_target = r_is_rinse ? S_RINSE : S_WASH;
      end
      S_WASH: begin
        w_active = 1'b1;
        w_flag   = tw;
        w_target = S_SPIN;
      end
      S_RINSE: begin
        w_active = 1'b1;
        w_flag   = tr;
        w_target = S_SPIN;
      end
      S_SPIN: begin
        w_active = 1'b1;
        w_flag   = ts;
        w_target = (r_rinse < c_RINSE) ? S_FILL : c_FINAL;
      end
`ifdef DRY_PHASE_EN
      S_DRY: begin
        w_active = 1'b1;
        w_flag   = td;
        w_target = S_DONE;
      end
`endif
      default: ;
    endcase
  end

  // Next state: abort beats door-open, and door-open beats the phase flag
  always_comb begin
    w_nxt = r_state;
    if (w_active) begin
      if (abort)
        w_nxt = S_IDLE;
      else if (!door_closed)
        w_nxt = S_PAUSE;
      else if (w_flag && (r_blank == '0))
        w_nxt = w_target;
    end else begin
      case (r_state)
        S_IDLE:  if (start && r_armed && door_closed && !abort) w_nxt = S_FILL;
        S_PAUSE: begin
          if (abort)
            w_nxt = S_IDLE;
          else if (door_closed && start)
            w_nxt = r_resume;
        end
        S_DONE:  if (!door_closed || abort) w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

`ifdef DRY_PHASE_EN
  assign w_nxt_run = (w_nxt inside {S_FILL, S_WASH, S_RINSE, S_SPIN, S_DRY});
`else
  assign w_nxt_run = (w_nxt inside {S_FILL, S_WASH, S_RINSE, S_SPIN});
  logic w_unused_td;
  assign w_unused_td = td;
`endif

  // A timed phase restarts its timer whenever it is newly entered, resumes included
  assign w_entry = w_nxt_run && (w_nxt != r_state);
  assign w_begin = (r_state == S_IDLE) && (w_nxt == S_FILL);
  assign w_abort = abort && (r_state != S_IDLE) && (r_state != S_DONE);

  assign phase = r_state;

  // Sequencer state, bookkeeping, and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_resume    <= S_IDLE;
      r_rinse     <= '0;
      r_is_rinse  <= 1'b0;
      r_armed     <= 1'b0;
      r_blank     <= '0;
      tmr_clr     <= 1'b0;
      tmr_load    <= '0;
      fill_valve  <= 1'b0;
      motor_wash  <= 1'b0;
      motor_spin  <= 1'b0;
      drain_valve <= 1'b0;
`ifdef DRY_PHASE_EN
      heater      <= 1'b0;
`endif
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state <= w_nxt;
      // start must be seen low while idle before a new cycle may begin
      r_armed <= (r_state == S_IDLE) ? (r_armed | ~start) : 1'b0;
      tmr_clr <= w_entry;

      if (w_entry)
        r_blank <= c_BLANK_INIT;
      else if (r_blank != '0)
        r_blank <= r_blank - 1'b1;

      if (w_begin) begin
        tmr_load   <= (load > 3'd2) ? 3'd2 : load;
        r_rinse    <= '0;
        r_is_rinse <= 1'b0;
      end else if (w_abort) begin
        tmr_load   <= '0;
        r_rinse    <= '0;
        r_is_rinse <= 1'b0;
        r_blank    <= '0;
      end else begin
        if ((r_state == S_RINSE) && (w_nxt == S_SPIN))
          r_rinse <= r_rinse + 3'd1;
        if ((r_state == S_SPIN) && (w_nxt == S_FILL))
          r_is_rinse <= 1'b1;
      end

      if (w_active && (w_nxt == S_PAUSE))
        r_resume <= r_state;

      fill_valve  <= (w_nxt == S_FILL);
      motor_wash  <= (w_nxt == S_WASH) || (w_nxt == S_RINSE);
      drain_valve <= (w_nxt == S_SPIN);
`ifdef DRY_PHASE_EN
      motor_spin  <= (w_nxt == S_SPIN) || (w_nxt == S_DRY);
      heater      <= (w_nxt == S_DRY);
`else
      motor_spin  <= (w_nxt == S_SPIN);
`endif
      busy        <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
      done        <= (w_nxt == S_DONE);
    end
  end

`ifndef DRY_PHASE_EN
  assign heater = 1'b0;
`endif

endmodule
`default_nettype wire
